// File: rtl/dmem_dp_copy.sv
// dmem_dp_copy: dual-port byte-lane data memory with a word copy engine that borrows port B.
module dmem_dp_copy #(
  parameter int DEPTH = 64,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we_a_i,
  input  logic [3:0]       be_a_i,
  input  logic [31:0]      a_a_i,
  input  logic [31:0]      wd_a_i,
  output logic [31:0]      rd_a_o,
  output logic             oob_a_o,
  input  logic             we_b_i,
  input  logic [3:0]       be_b_i,
  input  logic [31:0]      a_b_i,
  input  logic [31:0]      wd_b_i,
  output logic [31:0]      rd_b_o,
  output logic             oob_b_o,
  input  logic             cp_start_i,
  input  logic [31:0]      cp_src_i,
  input  logic [31:0]      cp_dst_i,
  input  logic [LEN_W-1:0] cp_len_i,
  output logic             cp_busy_o,
  output logic             cp_done_o,
  output logic             cp_err_o
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, COPY, DONE} state_t;
  state_t           st_q, st_d;
  logic [31:0]      mem_q [DEPTH];
  logic [31:0]      mem_d [DEPTH];
  logic [AW-1:0]    src_q, src_d, dst_q, dst_d, ia_a, ia_b;
  logic [LEN_W-1:0] len_q, len_d, cnt_q, cnt_d;
  logic             err_q, err_d, bad;
  logic [32:0]      src_end, dst_end;
  assign ia_a      = a_a_i[AW+1:2];
  assign ia_b      = a_b_i[AW+1:2];
  assign oob_a_o   = |a_a_i[31:AW+2];
  assign oob_b_o   = |a_b_i[31:AW+2];
  assign cp_busy_o = st_q == COPY;
  assign cp_done_o = st_q == DONE;
  assign cp_err_o  = err_q;
  assign rd_a_o    = oob_a_o ? '0 : mem_q[ia_a];
  assign rd_b_o    = (oob_b_o || cp_busy_o) ? '0 : mem_q[ia_b];
  // Sums are wide enough that an out-of-range request can never wrap into range
  assign src_end   = 33'(cp_src_i[31:2]) + 33'(cp_len_i);
  assign dst_end   = 33'(cp_dst_i[31:2]) + 33'(cp_len_i);
  assign bad       = (|cp_src_i[1:0]) || (|cp_dst_i[1:0]) ||
                     (src_end > 33'(DEPTH)) || (dst_end > 33'(DEPTH));
  always_comb begin
    st_d  = st_q;
    src_d = src_q;
    dst_d = dst_q;
    len_d = len_q;
    cnt_d = cnt_q;
    err_d = 1'b0;
    if (st_q == IDLE && cp_start_i) begin
      src_d = cp_src_i[AW+1:2];
      dst_d = cp_dst_i[AW+1:2];
      len_d = cp_len_i;
      cnt_d = '0;
      err_d = bad;
      st_d  = bad ? IDLE : (cp_len_i == '0 ? DONE : COPY);
    end else if (st_q == COPY) begin
      cnt_d = cnt_q + LEN_W'(1);
      st_d  = (cnt_q == len_q - LEN_W'(1)) ? DONE : COPY;
    end else if (st_q == DONE) begin
      st_d = IDLE;
    end
  end
  // Later assignments win: engine word, then port B lanes, then port A lanes on top
  always_comb begin
    mem_d = mem_q;
    if (cp_busy_o) mem_d[dst_q + AW'(cnt_q)] = mem_q[src_q + AW'(cnt_q)];
    for (int l = 0; l < 4; l++) begin
      if (we_b_i && !oob_b_o && !cp_busy_o && be_b_i[l]) mem_d[ia_b][8*l +: 8] = wd_b_i[8*l +: 8];
      if (we_a_i && !oob_a_o && be_a_i[l]) mem_d[ia_a][8*l +: 8] = wd_a_i[8*l +: 8];
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
      st_q  <= IDLE;
      src_q <= '0;
      dst_q <= '0;
      len_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      mem_q <= mem_d;
      st_q  <= st_d;
      src_q <= src_d;
      dst_q <= dst_d;
      len_q <= len_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_dmem_dp_copy.sv
// tb_dmem_dp_copy: directed vector table for the memory ports plus hand sequences for the copy engine.
module tb_dmem_dp_copy;
  localparam int DEPTH = 64;
  localparam int LEN_W = 16;
  logic clk = 1'b0, reset = 1'b1;
  logic we_a = 1'b0, we_b = 1'b0, cp_start = 1'b0;
  logic [3:0] be_a = '0, be_b = '0;
  logic [31:0] a_a = '0, wd_a = '0, a_b = '0, wd_b = '0, cp_src = '0, cp_dst = '0;
  logic [LEN_W-1:0] cp_len = '0;
  logic [31:0] rd_a, rd_b;
  logic oob_a, oob_b, cp_busy, cp_done, cp_err;
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  dmem_dp_copy #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset),
    .we_a_i(we_a), .be_a_i(be_a), .a_a_i(a_a), .wd_a_i(wd_a), .rd_a_o(rd_a), .oob_a_o(oob_a),
    .we_b_i(we_b), .be_b_i(be_b), .a_b_i(a_b), .wd_b_i(wd_b), .rd_b_o(rd_b), .oob_b_o(oob_b),
    .cp_start_i(cp_start), .cp_src_i(cp_src), .cp_dst_i(cp_dst), .cp_len_i(cp_len),
    .cp_busy_o(cp_busy), .cp_done_o(cp_done), .cp_err_o(cp_err)
  );

  typedef struct {
    logic we_a; logic [3:0] be_a; logic [31:0] a_a; logic [31:0] wd_a;
    logic we_b; logic [3:0] be_b; logic [31:0] a_b; logic [31:0] wd_b;
    logic [31:0] ex_a; logic [31:0] ex_b; logic ex_oa; logic ex_ob;
  } vec_t;
  vec_t v [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic rd_word(input int w, input logic [31:0] exp);
    a_a = 32'(w) << 2;
    #1 chk($sformatf("word%0d", w), rd_a, exp);
  endtask

  task automatic check_all_zero(input string tag);
    a_b = '0;
    for (int w = 0; w < DEPTH; w++) begin
      a_a = 32'(w) << 2;
      a_b = 32'(DEPTH - 1 - w) << 2;
      #1;
      chk({tag, "_rd_a"}, rd_a, 32'h0);
      chk({tag, "_rd_b"}, rd_b, 32'h0);
    end
  endtask

  task automatic run_req(input logic [31:0] s, input logic [31:0] d, input logic [LEN_W-1:0] n,
                         input logic e_err, input logic e_done);
    @(negedge clk);
    cp_src = s; cp_dst = d; cp_len = n; cp_start = 1'b1;
    @(negedge clk);
    cp_start = 1'b0;
    chk("req_err", 32'(cp_err), 32'(e_err));
    chk("req_done", 32'(cp_done), 32'(e_done));
    chk("req_busy", 32'(cp_busy), 32'h0);
    @(negedge clk);
    chk("req_err_clr", 32'(cp_err), 32'h0);
    chk("req_done_clr", 32'(cp_done), 32'h0);
  endtask

  initial begin
    int bcnt, dcnt, dfirst;
    // we_a be_a a_a wd_a | we_b be_b a_b wd_b | rd_a rd_b oob_a oob_b (values seen before the edge)
    v[0]  = '{1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 1'b0, 4'h0, 32'h10, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0};
    v[1]  = '{1'b1, 4'h4, 32'h10, 32'h00AA0000, 1'b0, 4'h0, 32'h10, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0};
    v[2]  = '{1'b0, 4'h0, 32'h10, 32'h0, 1'b0, 4'h0, 32'h13, 32'h0, 32'hDEAABEEF, 32'hDEAABEEF, 1'b0, 1'b0};
    v[3]  = '{1'b1, 4'h3, 32'h20, 32'h11112222, 1'b1, 4'h6, 32'h20, 32'h33334444, 32'h0, 32'h0, 1'b0, 1'b0};
    v[4]  = '{1'b0, 4'h0, 32'h20, 32'h0, 1'b0, 4'h0, 32'h22, 32'h0, 32'h00332222, 32'h00332222, 1'b0, 1'b0};
    v[5]  = '{1'b1, 4'hF, 32'h24, 32'h11111111, 1'b1, 4'hF, 32'h28, 32'h22222222, 32'h0, 32'h0, 1'b0, 1'b0};
    v[6]  = '{1'b0, 4'h0, 32'h24, 32'h0, 1'b0, 4'h0, 32'h28, 32'h0, 32'h11111111, 32'h22222222, 1'b0, 1'b0};
    v[7]  = '{1'b1, 4'hF, 32'h100, 32'hFFFFFFFF, 1'b1, 4'hF, 32'hFFFFFFFC, 32'hFFFFFFFF, 32'h0, 32'h0, 1'b1, 1'b1};
    v[8]  = '{1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h3FC, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1};
    v[9]  = '{1'b0, 4'h0, 32'hFC, 32'h0, 1'b1, 4'hF, 32'hFC, 32'hCAFEF00D, 32'h0, 32'h0, 1'b0, 1'b0};
    v[10] = '{1'b0, 4'h0, 32'hFC, 32'h0, 1'b0, 4'h0, 32'hFC, 32'h0, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 1'b0};

    repeat (2) @(negedge clk);
    check_all_zero("rst");
    chk("rst_busy", 32'(cp_busy), 32'h0);
    chk("rst_done", 32'(cp_done), 32'h0);
    chk("rst_err", 32'(cp_err), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    check_all_zero("post_rst");

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      we_a = v[i].we_a; be_a = v[i].be_a; a_a = v[i].a_a; wd_a = v[i].wd_a;
      we_b = v[i].we_b; be_b = v[i].be_b; a_b = v[i].a_b; wd_b = v[i].wd_b;
      #1;
      chk($sformatf("v%0d_rd_a", i), rd_a, v[i].ex_a);
      chk($sformatf("v%0d_rd_b", i), rd_b, v[i].ex_b);
      chk($sformatf("v%0d_oob_a", i), 32'(oob_a), 32'(v[i].ex_oa));
      chk($sformatf("v%0d_oob_b", i), 32'(oob_b), 32'(v[i].ex_ob));
    end
    @(negedge clk);
    we_a = 1'b0; we_b = 1'b0;
    rd_word(0, 32'h0);

    // Copy words 0..3 to 16..19 while port B keeps trying to write word 0
    for (int w = 0; w < 4; w++) begin
      @(negedge clk);
      we_a = 1'b1; be_a = 4'hF; a_a = 32'(w) << 2; wd_a = 32'(w + 1);
    end
    @(negedge clk);
    we_a = 1'b0;
    cp_src = 32'h0; cp_dst = 32'h40; cp_len = 4; cp_start = 1'b1;
    bcnt = 0; dcnt = 0; dfirst = -1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      cp_start = 1'b0;
      if (cp_busy) bcnt++;
      if (cp_done) begin
        dcnt++;
        if (dfirst < 0) dfirst = c;
      end
      if (c < 4) begin
        chk("copy_busy_on", 32'(cp_busy), 32'h1);
        a_b = 32'h0;
        #1 chk("copy_rd_b_blocked", rd_b, 32'h0);
        we_b = 1'b1; be_b = 4'hF; wd_b = 32'h00000BAD;
      end else begin
        we_b = 1'b0;
      end
    end
    chk("copy_busy_cycles", 32'(bcnt), 32'd4);
    chk("copy_done_pulses", 32'(dcnt), 32'd1);
    chk("copy_done_cycle", 32'(dfirst), 32'd4);
    for (int w = 0; w < 4; w++) rd_word(16 + w, 32'(w + 1));
    rd_word(20, 32'h0);
    a_b = 32'h40;
    #1 chk("copy_rd_b_free", rd_b, 32'h1);

    run_req(32'h2, 32'h80, 16'd1, 1'b1, 1'b0);
    run_req(32'h0, 32'(DEPTH - 2) * 4, 16'd3, 1'b1, 1'b0);
    run_req(32'h0, 32'h80, 16'd0, 1'b0, 1'b1);
    rd_word(62, 32'h0);
    rd_word(63, 32'hCAFEF00D);
    rd_word(32, 32'h0);
    rd_word(0, 32'h1);

    // Reset lands on the second busy cycle of an eight-word copy
    @(negedge clk);
    cp_src = 32'h0; cp_dst = 32'h80; cp_len = 8; cp_start = 1'b1;
    @(negedge clk);
    cp_start = 1'b0;
    chk("abort_busy_c1", 32'(cp_busy), 32'h1);
    @(negedge clk);
    reset = 1'b1;
    a_a = 32'h0;
    #1;
    chk("abort_rd_a_in_rst", rd_a, 32'h0);
    chk("abort_busy_in_rst", 32'(cp_busy), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    dcnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (cp_done || cp_busy || cp_err) dcnt++;
    end
    chk("abort_no_activity", 32'(dcnt), 32'h0);
    check_all_zero("abort");
    a_a = DEPTH * 4;
    #1;
    chk("abort_oob_a", 32'(oob_a), 32'h1);
    chk("abort_oob_rd_a", rd_a, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
